seq_alu: RTL

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Adds SLTU, shifts, and an iterative signed multiply and divide, each returning a 2*WIDTH result.
- Every operation is registered behind a valid/ready handshake, so the block fits single-cycle and multi-cycle/pipelined cores.
- Branch-condition evaluation uses the same opcodes as the existing ALU.

---
 rtl/seq_alu.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU. Single-cycle ops complete one cycle after accept; signed MUL and DIV
// run iteratively, one bit per cycle, and return a 2*WIDTH result (product, or quotient/remainder).
// Build option: define SEQ_ALU_MULDIV_EN to include the multi-cycle multiply/divide datapath.
// Without it, opcodes 14/15 complete in one cycle with zero results.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_out_hi,
  output logic             cond
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDone = 2'd3;
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic             accept;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic             br_taken, is_branch, alu_cond;
  logic             load;
  logic [WIDTH-1:0] lo_d, hi_d, lo_q, hi_q;
  logic             cond_d, cond_q;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign shamt     = data_in2[CW-1:0];
  assign is_branch = select inside {[4'd6:4'd9]};

  // Single-cycle result, evaluated directly from the operands presented at accept
  always_comb begin
    alu_res  = '0;
    br_taken = 1'b0;
    case (select)
      4'd0:    alu_res = data_in1 + data_in2;
      4'd1:    alu_res = data_in1 - data_in2;
      4'd2:    alu_res = data_in1 & data_in2;
      4'd3:    alu_res = data_in1 | data_in2;
      4'd4:    alu_res = data_in1 ^ data_in2;
      4'd5:    alu_res = {{(WIDTH-1){1'b0}}, $signed(data_in1) < $signed(data_in2)};
      4'd6:    br_taken = (data_in1 == data_in2);
      4'd7:    br_taken = (data_in1 != data_in2);
      4'd8:    br_taken = ($signed(data_in1) < $signed(data_in2));
      4'd9:    br_taken = ($signed(data_in1) >= $signed(data_in2));
      4'd10:   alu_res = {{(WIDTH-1){1'b0}}, data_in1 < data_in2};
      4'd11:   alu_res = data_in1 << shamt;
      4'd12:   alu_res = data_in1 >> shamt;
      4'd13:   alu_res = $unsigned($signed(data_in1) >>> shamt);
      default: alu_res = '0;  // MUL/DIV slots when the iterative unit is not built
    endcase
  end

  assign alu_cond = is_branch ? br_taken : (alu_res == '0);

`ifdef SEQ_ALU_MULDIV_EN
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] work_q;  // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_q;  // MUL: |multiplicand|; DIV: |divisor|
  logic               neg_q, rneg_q, dz_q;
  logic               last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_fix;
  logic [WIDTH-1:0]   div_rem, quo_fix, rem_fix;

  assign mag_a = data_in1[WIDTH-1] ? -data_in1 : data_in1;
  assign mag_b = data_in2[WIDTH-1] ? -data_in2 : data_in2;
  assign last  = (cnt_q == CW'(WIDTH - 1));

  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};
  assign mul_fix  = neg_q ? -mul_next : mul_next;

  // Restoring step: keep the trial difference only when it did not go negative
  assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_next  = {div_rem, work_q[WIDTH-2:0], ~div_trial[WIDTH]};
  // Divide-by-zero forces an all-ones quotient; the remainder naturally comes out as the dividend
  assign quo_fix   = dz_q ? '1 : (neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0]);
  assign rem_fix   = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

  // Iterative datapath: load magnitudes and signs on accept, then one bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      work_q <= '0;
      opnd_q <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (state_q == StIdle) begin
      if (accept && (select[3:1] == 3'b111)) begin
        cnt_q  <= '0;
        neg_q  <= data_in1[WIDTH-1] ^ data_in2[WIDTH-1];
        rneg_q <= data_in1[WIDTH-1];
        dz_q   <= (data_in2 == '0);
        if (select[0]) begin
          work_q <= {{WIDTH{1'b0}}, mag_a};
          opnd_q <= mag_b;
        end else begin
          work_q <= {{WIDTH{1'b0}}, mag_b};
          opnd_q <= mag_a;
        end
      end
    end else if (state_q == StMul) begin
      work_q <= mul_next;
      cnt_q  <= cnt_q + CW'(1);
    end else if (state_q == StDiv) begin
      work_q <= div_next;
      cnt_q  <= cnt_q + CW'(1);
    end
  end
`endif

  // Next state and the result to latch on entry to DONE
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    lo_d    = alu_res;
    hi_d    = '0;
    cond_d  = alu_cond;
    case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
          if (select == 4'd14) begin
            state_d = StMul;
          end else if (select == 4'd15) begin
            state_d = StDiv;
          end else begin
            state_d = StDone;
            load    = 1'b1;
          end
`else
          state_d = StDone;
          load    = 1'b1;
`endif
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      StMul: begin
        if (last) begin
          state_d = StDone;
          load    = 1'b1;
          lo_d    = mul_fix[WIDTH-1:0];
          hi_d    = mul_fix[2*WIDTH-1:WIDTH];
          cond_d  = (mul_fix[WIDTH-1:0] == '0);
        end
      end
      StDiv: begin
        if (last) begin
          state_d = StDone;
          load    = 1'b1;
          lo_d    = quo_fix;
          hi_d    = rem_fix;
          cond_d  = (quo_fix == '0);
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Output registers change only when a result is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= '0;
      hi_q   <= '0;
      cond_q <= 1'b0;
    end else if (load) begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      cond_q <= cond_d;
    end
  end

  assign data_out    = lo_q;
  assign data_out_hi = hi_q;
  assign cond        = cond_q;

endmodule
